// File: rtl/bcd_updown_counter_pkg.sv
// Shared definitions for the BCD up/down counter.
//   DIGIT_W       : width of one decimal digit field
//   clamp_digit   : limits a loaded digit to the highest legal digit value
//   all_max_word  : builds a word with every used digit set to the max digit
package bcd_updown_counter_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;

  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] value,
    input logic [DIGIT_W-1:0] max_digit
  );
    return (value > max_digit) ? max_digit : value;
  endfunction

  // Result is MAX_DIGITS wide; callers truncate to their own digit count.
  function automatic logic [DIGIT_W*MAX_DIGITS-1:0] all_max_word(
    input int                 num_digits,
    input logic [DIGIT_W-1:0] max_digit
  );
    logic [DIGIT_W*MAX_DIGITS-1:0] word;
    word = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < num_digits) word[i*DIGIT_W +: DIGIT_W] = max_digit;
    end
    return word;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_button_conditioner.sv
// Conditions one raw push-button into a single-cycle step pulse.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   btn   : raw asynchronous button level, active-high
//   pulse : one-cycle pulse per accepted press
// Two-flop synchroniser, then a debounce filter that only flips the accepted
// level after DEBOUNCE_CYCLES consecutive disagreeing samples, then a
// registered rising-edge detector.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_reg;
  logic          sync2_reg;
  logic [1:0]    valid_reg;
  logic          filt_reg;
  logic          filt_d_reg;
  logic [CW-1:0] cnt_reg;
  logic          armed_reg;
  logic          pulse_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      valid_reg  <= 2'b00;
      filt_reg   <= 1'b0;
      filt_d_reg <= 1'b0;
      cnt_reg    <= '0;
      armed_reg  <= 1'b0;
      pulse_reg  <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      // Marks when sync2 holds a genuine sample rather than its reset value.
      valid_reg <= {valid_reg[0], 1'b1};

      if (sync2_reg != filt_reg) begin
        if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
          filt_reg <= ~filt_reg;
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end

      filt_d_reg <= filt_reg;

      // A button held through reset must be seen released before it can
      // produce a step, so pulses stay blocked until a real low sample
      // arrives while the accepted level is low.
      if (valid_reg[1] && !sync2_reg && !filt_reg) armed_reg <= 1'b1;

      pulse_reg <= armed_reg && filt_reg && !filt_d_reg;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter driven by raw push-buttons.
//   clk, rst        : clock, synchronous active-high reset
//   btn_up/btn_down : raw asynchronous buttons, active-high
//   load, load_val  : synchronous parallel load (digits clamped to MAX_DIGIT)
//   count           : current value, 4 bits per digit, digit 0 in the LSBs
//   carry_out       : one-cycle pulse when an up step leaves/holds at max
//   borrow_out      : one-cycle pulse when a down step leaves/holds at min
//   at_max, at_min  : registered range flags, aligned with count
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int MAX_DIGIT       = 9,
  parameter int WRAP_EN         = 1,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          btn_up,
  input  logic                          btn_down,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
  output logic [DIGIT_W*NUM_DIGITS-1:0] count,
  output logic                          carry_out,
  output logic                          borrow_out,
  output logic                          at_max,
  output logic                          at_min
);

  localparam int                 W       = DIGIT_W * NUM_DIGITS;
  localparam logic [DIGIT_W-1:0] MAX_D   = DIGIT_W'(MAX_DIGIT);
  localparam logic [W-1:0]       ALL_MAX = W'(all_max_word(NUM_DIGITS, MAX_D));

  logic                  step_up;
  logic                  step_down;
  logic [W-1:0]          count_reg;
  logic [W-1:0]          count_next;
  logic                  carry_reg;
  logic                  carry_next;
  logic                  borrow_reg;
  logic                  borrow_next;
  logic                  at_max_reg;
  logic                  at_min_reg;
  logic [W-1:0]          inc_val;
  logic [W-1:0]          dec_val;
  logic [W-1:0]          clamp_val;
  logic [NUM_DIGITS-1:0] digit_max;
  logic [NUM_DIGITS-1:0] digit_zero;
  logic                  all_max;
  logic                  all_min;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_up),
    .pulse (step_up)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_down),
    .pulse (step_down)
  );

  // Per-digit arithmetic. A digit steps when every lower digit sits at its
  // end value; computing that from the lower digits directly keeps the ripple
  // a flat AND per digit instead of a self-referencing chain.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [DIGIT_W-1:0] d;
    logic               cin;
    logic               bin;

    assign d              = count_reg[gi*DIGIT_W +: DIGIT_W];
    assign digit_max[gi]  = (d == MAX_D);
    assign digit_zero[gi] = (d == '0);

    if (gi == 0) begin : g_lsd
      assign cin = 1'b1;
      assign bin = 1'b1;
    end else begin : g_upper
      assign cin = &digit_max[gi-1:0];
      assign bin = &digit_zero[gi-1:0];
    end

    assign inc_val[gi*DIGIT_W +: DIGIT_W] =
      cin ? (digit_max[gi] ? '0 : d + DIGIT_W'(1)) : d;
    assign dec_val[gi*DIGIT_W +: DIGIT_W] =
      bin ? (digit_zero[gi] ? MAX_D : d - DIGIT_W'(1)) : d;
    assign clamp_val[gi*DIGIT_W +: DIGIT_W] =
      clamp_digit(load_val[gi*DIGIT_W +: DIGIT_W], MAX_D);
  end

  assign all_max = &digit_max;
  assign all_min = &digit_zero;

  always_comb begin
    count_next  = count_reg;
    carry_next  = 1'b0;
    borrow_next = 1'b0;
    if (load) begin
      // Any step pulse in this cycle is dropped.
      count_next = clamp_val;
    end else if (step_up && !step_down) begin
      carry_next = all_max;
      if (!(all_max && WRAP_EN == 0)) count_next = inc_val;
    end else if (step_down && !step_up) begin
      borrow_next = all_min;
      if (!(all_min && WRAP_EN == 0)) count_next = dec_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= '0;
      carry_reg  <= 1'b0;
      borrow_reg <= 1'b0;
      at_max_reg <= 1'b0;
      at_min_reg <= 1'b1;
    end else begin
      count_reg  <= count_next;
      carry_reg  <= carry_next;
      borrow_reg <= borrow_next;
      at_max_reg <= (count_next == ALL_MAX);
      at_min_reg <= (count_next == '0);
    end
  end

  assign count      = count_reg;
  assign carry_out  = carry_reg;
  assign borrow_out = borrow_reg;
  assign at_max     = at_max_reg;
  assign at_min     = at_min_reg;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: a wrapping and a saturating instance share
// the same stimulus and are each compared against an integer model of the
// counter value (0..99) and of the expected carry/borrow pulse counts.
module tb_bcd_updown_counter;

  localparam int ND = 2;
  localparam int MD = 9;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up;
  logic       btn_down;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count_w, count_s;
  logic       carry_w, borrow_w, at_max_w, at_min_w;
  logic       carry_s, borrow_s, at_max_s, at_min_s;

  always #5 clk = ~clk;

  bcd_updown_counter #(.NUM_DIGITS(ND), .MAX_DIGIT(MD), .WRAP_EN(1), .DEBOUNCE_CYCLES(DB)) dut_wrap (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .load(load), .load_val(load_val),
    .count(count_w), .carry_out(carry_w), .borrow_out(borrow_w), .at_max(at_max_w), .at_min(at_min_w)
  );

  bcd_updown_counter #(.NUM_DIGITS(ND), .MAX_DIGIT(MD), .WRAP_EN(0), .DEBOUNCE_CYCLES(DB)) dut_sat (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .load(load), .load_val(load_val),
    .count(count_s), .carry_out(carry_s), .borrow_out(borrow_s), .at_max(at_max_s), .at_min(at_min_s)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: plain integer value of each counter plus pulse totals.
  int model_w = 0, model_s = 0;
  int exp_carry_w = 0, exp_borrow_w = 0, exp_carry_s = 0, exp_borrow_s = 0;
  int carry_cnt_w = 0, borrow_cnt_w = 0, carry_cnt_s = 0, borrow_cnt_s = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (carry_w)  carry_cnt_w++;
    if (borrow_w) borrow_cnt_w++;
    if (carry_s)  carry_cnt_s++;
    if (borrow_s) borrow_cnt_s++;
    if ((carry_w && borrow_w) || (carry_s && borrow_s)) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_load(input logic [7:0] lv);
    int hi, lo;
    hi = (int'(lv[7:4]) > MD) ? MD : int'(lv[7:4]);
    lo = (int'(lv[3:0]) > MD) ? MD : int'(lv[3:0]);
    return hi * 10 + lo;
  endfunction

  task automatic model_up();
    if (model_w == 99) begin model_w = 0; exp_carry_w++; end else model_w++;
    if (model_s == 99) exp_carry_s++; else model_s++;
  endtask

  task automatic model_down();
    if (model_w == 0) begin model_w = 99; exp_borrow_w++; end else model_w--;
    if (model_s == 0) exp_borrow_s++; else model_s--;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit up, input bit dn, input int hold, input int rel);
    btn_up = up;
    btn_down = dn;
    cycles(hold);
    btn_up = 1'b0;
    btn_down = 1'b0;
    cycles(rel);
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_val = v;
    cycles(1);
    load = 1'b0;
    cycles(1);
    model_w = clamp_load(v);
    model_s = model_w;
  endtask

  task automatic check_state(input string tag);
    $display("[TB] %s: count_w=%h count_s=%h model=%0d/%0d", tag, count_w, count_s, model_w, model_s);
    check({tag, "_count_w"}, count_w, to_bcd(model_w));
    check({tag, "_count_s"}, count_s, to_bcd(model_s));
    check({tag, "_at_max_w"}, at_max_w, model_w == 99);
    check({tag, "_at_min_w"}, at_min_w, model_w == 0);
    check({tag, "_at_max_s"}, at_max_s, model_s == 99);
    check({tag, "_at_min_s"}, at_min_s, model_s == 0);
  endtask

  task automatic check_pulses(input string tag);
    check({tag, "_carry_w"}, carry_cnt_w, exp_carry_w);
    check({tag, "_borrow_w"}, borrow_cnt_w, exp_borrow_w);
    check({tag, "_carry_s"}, carry_cnt_s, exp_carry_s);
    check({tag, "_borrow_s"}, borrow_cnt_s, exp_borrow_s);
  endtask

  initial begin
    rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; load = 1'b0; load_val = 8'h00;
    cycles(3);
    check("rst_count", count_w, 8'h00);
    check("rst_carry", carry_w, 1'b0);
    check("rst_borrow", borrow_w, 1'b0);
    check("rst_at_min", at_min_w, 1'b1);
    check("rst_at_max", at_max_w, 1'b0);
    rst = 1'b0;
    cycles(5);

    // 1: held button gives one step, 7 edges after the first sampled high.
    btn_up = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycles(1);
      check("t1_latency", count_w, (k >= 7) ? 8'h01 : 8'h00);
    end
    btn_up = 1'b0;
    cycles(DB + 2);
    model_up();
    press(1'b0, 1'b1, 3, DB + 2);   // glitch shorter than the debounce window
    check_state("t1");
    check_pulses("t1");

    // 2: up from 99 wraps / saturates, carry pulses once either way.
    do_load(8'h99);
    check_state("t2_load");
    press(1'b1, 1'b0, DB + 2, DB + 3);
    model_up();
    check_state("t2_up");
    check_pulses("t2");

    // 3: borrow ripple, count down to 0, then past it.
    do_load(8'h10);
    press(1'b0, 1'b1, DB + 2, DB + 3);
    model_down();
    check_state("t3_ripple");
    for (int i = 0; i < 9; i++) begin
      press(1'b0, 1'b1, DB + 1, DB + 2);
      model_down();
    end
    check_state("t3_zero");
    press(1'b0, 1'b1, DB + 1, DB + 2);
    model_down();
    check_state("t3_under");
    check_pulses("t3");

    // 4: coincident steps cancel; load beats a same-cycle step.
    do_load(8'h37);
    press(1'b1, 1'b1, DB + 2, DB + 3);
    check_state("t4_both");
    btn_up = 1'b1;
    cycles(7);                      // step pulse is high in this cycle
    load = 1'b1;
    load_val = 8'h42;
    cycles(1);
    load = 1'b0;
    cycles(1);
    btn_up = 1'b0;
    cycles(DB + 2);
    model_w = 42;
    model_s = 42;
    check_state("t4_load_step");
    check_pulses("t4");

    // 5: per-digit clamp on load; reset mid-debounce with the button held.
    do_load(8'hFC);
    check_state("t5_clamp");
    btn_up = 1'b1;
    cycles(3);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    model_w = 0;
    model_s = 0;
    cycles(15);
    check_state("t5_held");
    btn_up = 1'b0;
    cycles(DB + 2);
    check_state("t5_released");
    press(1'b1, 1'b0, DB + 1, DB + 2);
    model_up();
    check_state("t5_repress");
    check_pulses("t5");

    // 6: random press stream.
    for (int i = 0; i < 1000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45) begin
        press(1'b1, 1'b0, $urandom_range(DB + 1, DB + 4), $urandom_range(DB + 2, DB + 5));
        model_up();
      end else if (r < 90) begin
        press(1'b0, 1'b1, $urandom_range(DB + 1, DB + 4), $urandom_range(DB + 2, DB + 5));
        model_down();
      end else if (r < 94) begin
        press(1'($urandom_range(0, 1)), 1'b0, $urandom_range(1, DB - 1), DB + 2);
      end else if (r < 97) begin
        do_load(8'($urandom));
      end else begin
        press(1'b1, 1'b1, DB + 2, DB + 3);
      end
      check(("t6_count_w"), count_w, to_bcd(model_w));
      check(("t6_count_s"), count_s, to_bcd(model_s));
    end
    check_state("t6_end");
    check_pulses("t6");
    check("both_pulses", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Multi-digit decimal up/down counter driven directly by raw push-buttons, for the seven-segment display path.
- Each button is synchronised, debounced and edge-detected internally, so one press gives exactly one count step.
- Digit count, digit radix, wrap vs saturate mode and debounce length are parameters.
- Adds parallel load, carry/borrow pulses and min/max flags.
- Output feeds the seven-segment digit multiplexer.

Parameters:
- NUM_DIGITS, 4, number of cascaded digits (1..8).
- MAX_DIGIT, 9, highest value of each digit; digit radix = MAX_DIGIT+1 (1..15).
- WRAP_EN, 1, 1 = wrap at the ends of the range, 0 = saturate.
- DEBOUNCE_CYCLES, 100000, consecutive stable samples required before a button level is accepted (>=1).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset: synchronous, active-high.
- btn_up  in  1  raw asynchronous up button, active-high.
- btn_down  in  1  raw asynchronous down button, active-high.
- load  in  1  synchronous load strobe, already in the clk domain.
- load_val  in  4*NUM_DIGITS  digits to load, 4 bits per digit, digit 0 in the LSBs.
- count  out  4*NUM_DIGITS  current value, 4 bits per digit, digit 0 in the LSBs.
- carry_out  out  1  one-cycle pulse when an up step wraps or hits saturation at max.
- borrow_out  out  1  one-cycle pulse when a down step wraps or hits saturation at min.
- at_max  out  1  high while every digit = MAX_DIGIT.
- at_min  out  1  high while every digit = 0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - count=0, carry_out=0, borrow_out=0, at_min=1, at_max=0.
  - Synchroniser flops, filtered levels and debounce counters are cleared to 0.
  - A button held through reset produces no step until it is released and pressed again.
- Button conditioning, per button:
  - Two-flop synchroniser.
  - Filtered level toggles only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample resets the debounce counter.
  - The step pulse is high for exactly one cycle on a 0->1 transition of the filtered level.
- Latency: with a clean press starting before edge N, the step pulse is high in cycle N+2+DEBOUNCE_CYCLES and count changes at the next edge.
- Priority at each edge, highest first:
  1. rst.
  2. load.
  3. Both step pulses in the same cycle: no count change, no pulses.
  4. A single up or down step.
- Load: count takes load_val. Any digit >MAX_DIGIT is clamped to MAX_DIGIT. A step pulse in the same cycle is discarded, not deferred.
- Up step:
  - Digit 0 increments.
  - A digit at MAX_DIGIT goes to 0 and carries into the next digit; the ripple resolves in the same cycle.
  - All digits at MAX_DIGIT: WRAP_EN=1 gives all zeros; WRAP_EN=0 holds. In both cases carry_out=1 for one cycle.
- Down step:
  - Symmetric to the up step: a digit at 0 goes to MAX_DIGIT and borrows.
  - All digits at 0: wraps to all MAX_DIGIT (WRAP_EN=1) or holds (WRAP_EN=0). borrow_out=1 for one cycle.
- Pulses and flags:
  - carry_out and borrow_out are registered and never high together.
  - at_max and at_min are registered from the next count value, so they are valid in the same cycle as count.
- Arithmetic is per-digit, 4 bits wide; there is no binary-to-BCD conversion.

Decomposition:
- Shared package:
  - DIGIT_W=4.
  - Function clamp_digit(value, max).
  - Function that builds the all-MAX_DIGIT constant of width 4*NUM_DIGITS.
- One sub-module, button_conditioner: synchroniser, debounce counter and rising-edge pulse, parameter DEBOUNCE_CYCLES. It is instantiated twice, once per button.
- Digit arithmetic stays in the top module as a generate loop.

Test Plan (NUM_DIGITS=2, MAX_DIGIT=9, DEBOUNCE_CYCLES=4 unless stated):
1. Reset, then btn_up held high 20 cycles -> exactly one step: count=8'h01 exactly 7 cycles after the first sampled high; no further change while held; a 3-cycle glitch on btn_down -> no change.
2. Load 8'h99, press up -> count=8'h00 and carry_out high one cycle. Repeat with WRAP_EN=0 -> count stays 8'h99, carry_out still pulses once.
3. Load 8'h10, press down -> count=8'h09 (borrow ripple), no borrow_out. Press down 9 more times -> 8'h00 with at_min=1. One further press -> 8'h99 and borrow_out=1.
4. Step pulses forced coincident on both buttons -> count unchanged, no pulses. load=1 in the same cycle as an up step with load_val=8'h42 -> count=8'h42 and the step is discarded.
5. load_val=8'hFC -> count=8'h99 (per-digit clamp) and at_max=1. rst asserted mid-debounce with button held -> count=0, no step after reset until release and re-press.
6. Random press stream (1000 presses, WRAP_EN=1) checked against a reference model of count modulo 100 -> no mismatches; no cycle with carry_out and borrow_out both high.
